// File: rtl/dmem_bridge_if.sv
`default_nettype none
// ============================================================================
// Module   : dmem_bridge_if
// Brief    : Core-side load/store bus and SRAM-side port bundle for dmem_bridge.
// Revision : 1.0
// ============================================================================
interface dmem_bridge_if #(
    parameter int ADDR_W = 10
);
    logic              mem_req;
    logic              mem_we;
    logic [31:0]       mem_addr;
    logic [31:0]       mem_wdata;
    logic [2:0]        mem_dmtype;
    logic [31:0]       mem_rdata;
    logic              mem_done;
    logic              mem_busy;
    logic              mem_err;
    logic              sram_en;
    logic [3:0]        sram_we;
    logic [ADDR_W-1:0] sram_addr;
    logic [31:0]       sram_wdata;
    logic [31:0]       sram_rdata;

    // master: the core plus the SRAM macro; slave: the bridge itself
    modport master (
        output mem_req, mem_we, mem_addr, mem_wdata, mem_dmtype, sram_rdata,
        input  mem_rdata, mem_done, mem_busy, mem_err,
        input  sram_en, sram_we, sram_addr, sram_wdata
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_wdata, mem_dmtype, sram_rdata,
        output mem_rdata, mem_done, mem_busy, mem_err,
        output sram_en, sram_we, sram_addr, sram_wdata
    );
endinterface
`default_nettype wire

// File: rtl/dmem_bridge.sv
`default_nettype none
// ============================================================================
// Module   : dmem_bridge
// Brief    : Load/store responder: lane placement, alignment, load extension,
//            word SRAM with RD_LAT-cycle access. Optional macro
//            DMEM_BRIDGE_MISALIGN_TRAP_EN traps misaligned accesses.
// Revision : 1.0
// ============================================================================
module dmem_bridge #(
    parameter int ADDR_W = 10,
    parameter int RD_LAT = 1
) (
    input  wire logic    clk,
    input  wire logic    rst,
    dmem_bridge_if.slave bus
);
    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_DONE   = 2'd2
    } state_t;

    localparam logic [3:0] c_rd_lat = 4'(RD_LAT);

    state_t            r_state, w_state_nx;
    logic [3:0]        r_cnt, w_cnt_nx;
    logic              r_we, w_we_nx;
    logic [2:0]        r_dmtype, w_dmtype_nx;
    logic [1:0]        r_off, w_off_nx;
    logic              r_sram_en, w_sram_en_nx;
    logic [3:0]        r_sram_we, w_sram_we_nx;
    logic [ADDR_W-1:0] r_sram_addr, w_sram_addr_nx;
    logic [31:0]       r_sram_wdata, w_sram_wdata_nx;
    logic [31:0]       r_rdata, w_rdata_nx;
    logic              r_done, w_done_nx;
    logic              r_busy, w_busy_nx;
    logic              r_err, w_err_nx;

    logic              w_is_half;
    logic              w_is_byte;
    logic              w_trap;
    logic [1:0]        w_req_off;
    logic [3:0]        w_req_be;
    logic [31:0]       w_req_wdata;
    logic [7:0]        w_ld_byte;
    logic [15:0]       w_ld_half;
    logic [31:0]       w_ld_data;
    logic              w_unused_addr;

    assign w_is_half     = (bus.mem_dmtype == 3'b001) || (bus.mem_dmtype == 3'b010);
    assign w_is_byte     = (bus.mem_dmtype == 3'b011) || (bus.mem_dmtype == 3'b100);
    assign w_unused_addr = ^bus.mem_addr[31:ADDR_W+2];

`ifdef DMEM_BRIDGE_MISALIGN_TRAP_EN
    assign w_trap = (w_is_half && bus.mem_addr[0]) ||
                    (!w_is_half && !w_is_byte && (bus.mem_addr[1:0] != 2'b00));
`else
    assign w_trap = 1'b0;
`endif

    // Offsets are force-aligned; with trapping enabled misaligned requests never reach ACCESS.
    always_comb begin
        w_req_off   = 2'b00;
        w_req_be    = 4'b1111;
        w_req_wdata = bus.mem_wdata;
        if (w_is_byte) begin
            w_req_off   = bus.mem_addr[1:0];
            w_req_be    = 4'b0001 << bus.mem_addr[1:0];
            w_req_wdata = {4{bus.mem_wdata[7:0]}};
        end else if (w_is_half) begin
            w_req_off   = {bus.mem_addr[1], 1'b0};
            w_req_be    = bus.mem_addr[1] ? 4'b1100 : 4'b0011;
            w_req_wdata = {2{bus.mem_wdata[15:0]}};
        end
    end

    always_comb begin
        case (r_off)
            2'd0:    w_ld_byte = bus.sram_rdata[7:0];
            2'd1:    w_ld_byte = bus.sram_rdata[15:8];
            2'd2:    w_ld_byte = bus.sram_rdata[23:16];
            default: w_ld_byte = bus.sram_rdata[31:24];
        endcase
        w_ld_half = r_off[1] ? bus.sram_rdata[31:16] : bus.sram_rdata[15:0];
        case (r_dmtype)
            3'b001:  w_ld_data = {{16{w_ld_half[15]}}, w_ld_half};
            3'b010:  w_ld_data = {16'd0, w_ld_half};
            3'b011:  w_ld_data = {{24{w_ld_byte[7]}}, w_ld_byte};
            3'b100:  w_ld_data = {24'd0, w_ld_byte};
            default: w_ld_data = bus.sram_rdata;
        endcase
    end

    always_comb begin
        w_state_nx      = r_state;
        w_cnt_nx        = r_cnt;
        w_we_nx         = r_we;
        w_dmtype_nx     = r_dmtype;
        w_off_nx        = r_off;
        w_sram_en_nx    = 1'b0;
        w_sram_we_nx    = 4'b0000;
        w_sram_addr_nx  = r_sram_addr;
        w_sram_wdata_nx = r_sram_wdata;
        w_rdata_nx      = 32'd0;
        w_done_nx       = 1'b0;
        w_busy_nx       = 1'b0;
        w_err_nx        = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (bus.mem_req) begin
                    w_we_nx     = bus.mem_we;
                    w_dmtype_nx = bus.mem_dmtype;
                    w_off_nx    = w_req_off;
                    w_busy_nx   = 1'b1;
                    if (w_trap) begin
                        w_state_nx = S_DONE;
                        w_done_nx  = 1'b1;
                        w_err_nx   = 1'b1;
                    end else begin
                        w_state_nx      = S_ACCESS;
                        w_cnt_nx        = c_rd_lat;
                        w_sram_en_nx    = 1'b1;
                        w_sram_we_nx    = bus.mem_we ? w_req_be : 4'b0000;
                        w_sram_addr_nx  = bus.mem_addr[ADDR_W+1:2];
                        w_sram_wdata_nx = w_req_wdata;
                    end
                end
            end
            S_ACCESS: begin
                w_busy_nx    = 1'b1;
                w_sram_en_nx = 1'b1;
                w_cnt_nx     = r_cnt - 4'd1;
                if (r_cnt == 4'd1) begin
                    w_state_nx   = S_DONE;
                    w_sram_en_nx = 1'b0;
                    w_done_nx    = 1'b1;
                    w_rdata_nx   = r_we ? 32'd0 : w_ld_data;
                end
            end
            S_DONE: begin
                w_state_nx = S_IDLE;
            end
            default: begin
                w_state_nx = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_cnt        <= 4'd0;
            r_we         <= 1'b0;
            r_dmtype     <= 3'd0;
            r_off        <= 2'd0;
            r_sram_en    <= 1'b0;
            r_sram_we    <= 4'b0000;
            r_sram_addr  <= '0;
            r_sram_wdata <= 32'd0;
            r_rdata      <= 32'd0;
            r_done       <= 1'b0;
            r_busy       <= 1'b0;
            r_err        <= 1'b0;
        end else begin
            r_state      <= w_state_nx;
            r_cnt        <= w_cnt_nx;
            r_we         <= w_we_nx;
            r_dmtype     <= w_dmtype_nx;
            r_off        <= w_off_nx;
            r_sram_en    <= w_sram_en_nx;
            r_sram_we    <= w_sram_we_nx;
            r_sram_addr  <= w_sram_addr_nx;
            r_sram_wdata <= w_sram_wdata_nx;
            r_rdata      <= w_rdata_nx;
            r_done       <= w_done_nx;
            r_busy       <= w_busy_nx;
            r_err        <= w_err_nx;
        end
    end

    assign bus.mem_rdata  = r_rdata;
    assign bus.mem_done   = r_done;
    assign bus.mem_busy   = r_busy;
    assign bus.mem_err    = r_err;
    assign bus.sram_en    = r_sram_en;
    assign bus.sram_we    = r_sram_we;
    assign bus.sram_addr  = r_sram_addr;
    assign bus.sram_wdata = r_sram_wdata;
endmodule
`default_nettype wire

// File: tb/tb_dmem_bridge.sv
`default_nettype none
// ============================================================================
// Module   : tb_dmem_bridge
// Brief    : Three bridges (RD_LAT 1/3/4) against a byte-addressed memory model.
// Revision : 1.0
// ============================================================================
module tb_dmem_bridge;
`ifdef DMEM_BRIDGE_MISALIGN_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          lat;
        int          en_cyc;
        int          we_cyc;
        logic [3:0]  be;
        logic [31:0] swdata;
        logic [9:0]  saddr;
        logic        late_done;
    } obs_t;

    logic        clk;
    logic        rst;
    logic        req     [3];
    logic        we_i    [3];
    logic [31:0] addr_i  [3];
    logic [31:0] wdata_i [3];
    logic [2:0]  dt_i    [3];
    wire  [31:0] rdata_o [3];
    wire         done_o  [3];
    wire         busy_o  [3];
    wire         err_o   [3];
    wire         en_o    [3];
    wire  [3:0]  sbe_o   [3];
    wire  [9:0]  saddr_o [3];
    wire  [31:0] swdata_o[3];

    logic [7:0]  mdl [3][4096];
    int          checks = 0;
    int          errors = 0;

    function automatic logic [31:0] init_word(input int k, input int i);
        return (32'(i) * 32'h9E37_79B1) ^ (32'(k) << 28) ^ 32'h5A5A_1234;
    endfunction

    for (genvar k = 0; k < 3; k++) begin : g_dut
        localparam int LAT = (k == 0) ? 1 : (k == 1) ? 3 : 4;
        dmem_bridge_if #(.ADDR_W(10)) bus ();
        logic [31:0] mem [1024];

        assign bus.mem_req    = req[k];
        assign bus.mem_we     = we_i[k];
        assign bus.mem_addr   = addr_i[k];
        assign bus.mem_wdata  = wdata_i[k];
        assign bus.mem_dmtype = dt_i[k];
        assign bus.sram_rdata = mem[bus.sram_addr];
        assign rdata_o[k]     = bus.mem_rdata;
        assign done_o[k]      = bus.mem_done;
        assign busy_o[k]      = bus.mem_busy;
        assign err_o[k]       = bus.mem_err;
        assign en_o[k]        = bus.sram_en;
        assign sbe_o[k]       = bus.sram_we;
        assign saddr_o[k]     = bus.sram_addr;
        assign swdata_o[k]    = bus.sram_wdata;

        dmem_bridge #(.ADDR_W(10), .RD_LAT(LAT)) u_dut (
            .clk (clk),
            .rst (rst),
            .bus (bus)
        );

        initial begin
            for (int i = 0; i < 1024; i++) mem[i] = init_word(k, i);
        end

        always @(posedge clk) begin
            if (bus.sram_en) begin
                for (int b = 0; b < 4; b++)
                    if (bus.sram_we[b]) mem[bus.sram_addr][8*b +: 8] <= bus.sram_wdata[8*b +: 8];
            end
        end
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    function automatic int lat_of(input int d);
        return (d == 0) ? 1 : (d == 1) ? 3 : 4;
    endfunction

    function automatic int sz(input logic [2:0] dt);
        case (dt)
            3'd1, 3'd2: return 2;
            3'd3, 3'd4: return 1;
            default:    return 4;
        endcase
    endfunction

    function automatic bit is_mis(input logic [31:0] a, input logic [2:0] dt);
        return (int'(a[11:0]) % sz(dt)) != 0;
    endfunction

    function automatic int base(input logic [31:0] a, input logic [2:0] dt);
        return int'(a[11:0]) & ~(sz(dt) - 1);
    endfunction

    function automatic logic [31:0] mdl_load(input int d, input logic [31:0] a, input logic [2:0] dt);
        logic [31:0] v;
        v = 32'd0;
        for (int i = 0; i < sz(dt); i++) v = v | (32'(mdl[d][base(a, dt) + i]) << (8 * i));
        if (dt == 3'd1 && v[15]) v = v | 32'hFFFF_0000;
        if (dt == 3'd3 && v[7])  v = v | 32'hFFFF_FF00;
        return v;
    endfunction

    task automatic mdl_store(input int d, input logic [31:0] a, input logic [31:0] wd, input logic [2:0] dt);
        if (!(TRAP && is_mis(a, dt)))
            for (int i = 0; i < sz(dt); i++) mdl[d][base(a, dt) + i] = wd[8*i +: 8];
    endtask

    function automatic logic [3:0] exp_be(input logic [31:0] a, input logic [2:0] dt);
        logic [3:0] m;
        m = 4'b0000;
        for (int i = 0; i < sz(dt); i++) m[(base(a, dt) % 4) + i] = 1'b1;
        return m;
    endfunction

    function automatic logic [31:0] exp_wdata(input logic [31:0] wd, input logic [2:0] dt);
        logic [31:0] v;
        v = 32'd0;
        for (int l = 0; l < 4; l++) v[8*l +: 8] = wd[8*(l % sz(dt)) +: 8];
        return v;
    endfunction

    // ---------------- stimulus driver (no checking) ----------------
    task automatic do_access(input int d, input logic w, input logic [31:0] a,
                             input logic [31:0] wd, input logic [2:0] dt, output obs_t o);
        o = '{rdata: 32'd0, err: 1'b0, lat: 0, en_cyc: 0, we_cyc: 0, be: 4'd0,
              swdata: 32'd0, saddr: 10'd0, late_done: 1'b0};
        @(negedge clk);
        req[d] = 1'b1; we_i[d] = w; addr_i[d] = a; wdata_i[d] = wd; dt_i[d] = dt;
        @(posedge clk);
        @(negedge clk);
        req[d] = 1'b0;
        for (int i = 1; i <= 40; i++) begin
            if (i > 1) @(negedge clk);
            if (en_o[d]) begin
                o.en_cyc++;
                o.saddr = saddr_o[d];
            end
            if (sbe_o[d] != 4'd0) begin
                o.we_cyc++;
                o.be     = sbe_o[d];
                o.swdata = swdata_o[d];
            end
            if (done_o[d]) begin
                o.lat   = i;
                o.rdata = rdata_o[d];
                o.err   = err_o[d];
                break;
            end
        end
        @(negedge clk);
        o.late_done = done_o[d];
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        @(negedge clk);
        @(negedge clk);
        for (int d = 0; d < 3; d++) begin
            checks++;
            if ({rdata_o[d], done_o[d], busy_o[d], err_o[d]} !== 35'd0) begin
                errors++;
                $display("FAIL reset_mem dut%0d: rdata=%h done=%b busy=%b err=%b, required all 0",
                         d, rdata_o[d], done_o[d], busy_o[d], err_o[d]);
            end
            checks++;
            if ({en_o[d], sbe_o[d], saddr_o[d], swdata_o[d]} !== 47'd0) begin
                errors++;
                $display("FAIL reset_sram dut%0d: en=%b we=%b addr=%h wdata=%h, required all 0",
                         d, en_o[d], sbe_o[d], saddr_o[d], swdata_o[d]);
            end
        end
        rst = 1'b0;
    endtask

    task automatic test_word_store();
        obs_t o;
        do_access(0, 1'b1, 32'h8, 32'hDEAD_BEEF, 3'b000, o);
        checks++; if (o.saddr !== 10'd2) begin errors++; $display("FAIL wst_addr: got %0d want 2", o.saddr); end
        checks++; if (o.be !== 4'b1111) begin errors++; $display("FAIL wst_we: got %b want 1111", o.be); end
        checks++; if (o.swdata !== 32'hDEAD_BEEF) begin errors++; $display("FAIL wst_wdata: got %h want deadbeef", o.swdata); end
        checks++; if (o.lat != 2) begin errors++; $display("FAIL wst_latency: got %0d want 2", o.lat); end
        checks++; if (o.rdata !== 32'd0) begin errors++; $display("FAIL wst_rdata: got %h want 0", o.rdata); end
        checks++; if (o.late_done !== 1'b0) begin errors++; $display("FAIL wst_done_width: got %b want 0", o.late_done); end
        mdl_store(0, 32'h8, 32'hDEAD_BEEF, 3'b000);
        do_access(0, 1'b0, 32'h8, 32'd0, 3'b000, o);
        checks++; if (o.rdata !== 32'hDEAD_BEEF) begin errors++; $display("FAIL wld_rdata: got %h want deadbeef", o.rdata); end
    endtask

    task automatic test_byte_lanes();
        obs_t o;
        do_access(0, 1'b1, 32'h13, 32'h0000_00A5, 3'b011, o);
        checks++; if (o.be !== 4'b1000) begin errors++; $display("FAIL bst_we: got %b want 1000", o.be); end
        checks++; if (o.swdata !== 32'hA5A5_A5A5) begin errors++; $display("FAIL bst_wdata: got %h want a5a5a5a5", o.swdata); end
        mdl_store(0, 32'h13, 32'h0000_00A5, 3'b011);
        do_access(0, 1'b0, 32'h13, 32'd0, 3'b011, o);
        checks++; if (o.rdata !== 32'hFFFF_FFA5) begin errors++; $display("FAIL lb_sext: got %h want ffffffa5", o.rdata); end
        do_access(0, 1'b0, 32'h13, 32'd0, 3'b100, o);
        checks++; if (o.rdata !== 32'h0000_00A5) begin errors++; $display("FAIL lbu_zext: got %h want 000000a5", o.rdata); end
    endtask

    task automatic test_half_lanes();
        obs_t o;
        do_access(0, 1'b1, 32'h6, 32'h0000_8001, 3'b001, o);
        checks++; if (o.be !== 4'b1100) begin errors++; $display("FAIL hst_we: got %b want 1100", o.be); end
        checks++; if (o.swdata !== 32'h8001_8001) begin errors++; $display("FAIL hst_wdata: got %h want 80018001", o.swdata); end
        mdl_store(0, 32'h6, 32'h0000_8001, 3'b001);
        do_access(0, 1'b0, 32'h6, 32'd0, 3'b001, o);
        checks++; if (o.rdata !== 32'hFFFF_8001) begin errors++; $display("FAIL lh_sext: got %h want ffff8001", o.rdata); end
        do_access(0, 1'b0, 32'h6, 32'd0, 3'b010, o);
        checks++; if (o.rdata !== 32'h0000_8001) begin errors++; $display("FAIL lhu_zext: got %h want 00008001", o.rdata); end
    endtask

    task automatic test_misaligned();
        obs_t o;
        logic [31:0] er;
        er = TRAP ? 32'd0 : mdl_load(0, 32'h0, 3'b000);
        do_access(0, 1'b0, 32'h2, 32'd0, 3'b000, o);
        checks++; if (o.err !== TRAP) begin errors++; $display("FAIL mis_err: got %b want %b", o.err, TRAP); end
        checks++; if (o.lat != (TRAP ? 1 : 2)) begin errors++; $display("FAIL mis_latency: got %0d want %0d", o.lat, TRAP ? 1 : 2); end
        checks++; if (o.en_cyc != (TRAP ? 0 : 1)) begin errors++; $display("FAIL mis_sram_en: got %0d cycles want %0d", o.en_cyc, TRAP ? 0 : 1); end
        checks++; if (o.rdata !== er) begin errors++; $display("FAIL mis_rdata: got %h want %h", o.rdata, er); end
        checks++; if (o.saddr !== 10'd0) begin errors++; $display("FAIL mis_addr: got %0d want 0", o.saddr); end
    endtask

    task automatic test_reset_mid_access();
        obs_t o;
        logic seen;
        @(negedge clk);
        req[1] = 1'b1; we_i[1] = 1'b0; addr_i[1] = 32'h24; dt_i[1] = 3'b000;
        @(posedge clk);
        @(negedge clk);
        req[1] = 1'b0;
        checks++; if (en_o[1] !== 1'b1) begin errors++; $display("FAIL rma_access: en=%b want 1", en_o[1]); end
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({en_o[1], sbe_o[1], busy_o[1]} !== 6'd0) begin
            errors++;
            $display("FAIL rma_abort: en=%b we=%b busy=%b want all 0", en_o[1], sbe_o[1], busy_o[1]);
        end
        @(negedge clk);
        rst = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            seen = seen | done_o[1];
        end
        checks++; if (seen !== 1'b0) begin errors++; $display("FAIL rma_no_done: done seen=%b want 0", seen); end
        do_access(1, 1'b0, 32'h24, 32'd0, 3'b000, o);
        checks++; if (o.lat != 4) begin errors++; $display("FAIL rma_after_latency: got %0d want 4", o.lat); end
        checks++; if (o.rdata !== mdl_load(1, 32'h24, 3'b000)) begin
            errors++; $display("FAIL rma_after_rdata: got %h want %h", o.rdata, mdl_load(1, 32'h24, 3'b000));
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] e1, e2, r1, r2;
        int t1, t2;
        e1 = mdl_load(2, 32'h40, 3'b000);
        e2 = mdl_load(2, 32'h84, 3'b000);
        t1 = 0; t2 = 0; r1 = 32'd0; r2 = 32'd0;
        @(negedge clk);
        req[2] = 1'b1; we_i[2] = 1'b0; addr_i[2] = 32'h40; dt_i[2] = 3'b000;
        @(posedge clk);
        @(negedge clk);
        addr_i[2] = 32'h84;
        for (int i = 1; i <= 30; i++) begin
            if (i > 1) @(negedge clk);
            if (done_o[2]) begin
                if (t1 == 0) begin
                    t1 = i; r1 = rdata_o[2];
                end else begin
                    t2 = i; r2 = rdata_o[2];
                    break;
                end
            end
        end
        req[2] = 1'b0;
        @(negedge clk);
        @(negedge clk);
        checks++; if (t1 != 5) begin errors++; $display("FAIL b2b_first_done: at %0d want 5", t1); end
        checks++; if (t2 - t1 != 6) begin errors++; $display("FAIL b2b_spacing: got %0d want 6", t2 - t1); end
        checks++; if (r1 !== e1) begin errors++; $display("FAIL b2b_rdata1: got %h want %h", r1, e1); end
        checks++; if (r2 !== e2) begin errors++; $display("FAIL b2b_rdata2: got %h want %h", r2, e2); end
    endtask

    task automatic test_random();
        obs_t o;
        logic w;
        logic [31:0] a, wd, er;
        logic [2:0] dt;
        bit trap;
        int d, el;
        for (int n = 0; n < 90; n++) begin
            d  = n % 3;
            w  = 1'($urandom_range(0, 1));
            a  = ($urandom & 32'hFFFF_F000) | 32'($urandom_range(0, 63));
            wd = $urandom;
            dt = 3'($urandom_range(0, 7));
            trap = TRAP && is_mis(a, dt);
            er = (w || trap) ? 32'd0 : mdl_load(d, a, dt);
            el = trap ? 1 : lat_of(d) + 1;
            do_access(d, w, a, wd, dt, o);
            checks++; if (o.lat != el) begin errors++; $display("FAIL rnd_latency dut%0d a=%h dt=%0d: got %0d want %0d", d, a, dt, o.lat, el); end
            checks++; if (o.err !== trap) begin errors++; $display("FAIL rnd_err dut%0d a=%h dt=%0d: got %b want %b", d, a, dt, o.err, trap); end
            checks++; if (o.rdata !== er) begin errors++; $display("FAIL rnd_rdata dut%0d a=%h dt=%0d we=%b: got %h want %h", d, a, dt, w, o.rdata, er); end
            checks++; if (o.en_cyc != (trap ? 0 : lat_of(d))) begin errors++; $display("FAIL rnd_en_cycles dut%0d: got %0d want %0d", d, o.en_cyc, trap ? 0 : lat_of(d)); end
            checks++; if (o.we_cyc != ((w && !trap) ? 1 : 0)) begin errors++; $display("FAIL rnd_we_cycles dut%0d: got %0d want %0d", d, o.we_cyc, (w && !trap) ? 1 : 0); end
            checks++; if (o.late_done !== 1'b0) begin errors++; $display("FAIL rnd_done_width dut%0d: got %b want 0", d, o.late_done); end
            if (!trap) begin
                checks++; if (o.saddr !== 10'(base(a, dt) / 4)) begin errors++; $display("FAIL rnd_addr dut%0d a=%h: got %h want %h", d, a, o.saddr, 10'(base(a, dt) / 4)); end
            end
            if (w && !trap) begin
                checks++; if (o.be !== exp_be(a, dt)) begin errors++; $display("FAIL rnd_be dut%0d a=%h dt=%0d: got %b want %b", d, a, dt, o.be, exp_be(a, dt)); end
                checks++; if (o.swdata !== exp_wdata(wd, dt)) begin errors++; $display("FAIL rnd_wdata dut%0d dt=%0d: got %h want %h", d, dt, o.swdata, exp_wdata(wd, dt)); end
            end
            if (w) mdl_store(d, a, wd, dt);
        end
    endtask

    initial begin
        rst = 1'b1;
        for (int d = 0; d < 3; d++) begin
            req[d] = 1'b0; we_i[d] = 1'b0; addr_i[d] = 32'd0; wdata_i[d] = 32'd0; dt_i[d] = 3'd0;
            for (int i = 0; i < 4096; i++) mdl[d][i] = init_word(d, i / 4)[8*(i % 4) +: 8];
        end
        test_reset();
        test_word_store();
        test_byte_lanes();
        test_half_lanes();
        test_misaligned();
        test_reset_mid_access();
        test_back_to_back();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/dmem_bridge.md
Name: dmem_bridge

Overview:
- Data-memory responder for the RISC-V SCPU core's load/store path.
- Accepts a decoded load/store request (write enable, byte address, store data, DMType) and performs byte-lane placement, alignment checking and load sign/zero extension.
- Drives a word-wide synchronous SRAM with byte enables and a configurable read latency.
- Reports completion to the core with a one-cycle done pulse; the core stalls on busy.

Parameters:
- ADDR_W, 10, SRAM word-address width (SRAM depth = 2^ADDR_W words).
- RD_LAT, 1, SRAM access latency in cycles (legal range 1..15).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- mem_req  in  1  request strobe; sampled only when busy=0.
- mem_we  in  1  1=store, 0=load.
- mem_addr  in  32  byte address.
- mem_wdata  in  32  store data, right-justified.
- mem_dmtype  in  3  000 word, 001 half, 010 half unsigned, 011 byte, 100 byte unsigned.
- mem_rdata  out  32  load result, extended; valid while mem_done=1.
- mem_done  out  1  one-cycle completion pulse.
- mem_busy  out  1  request in flight; new requests ignored.
- mem_err  out  1  misaligned access flag; valid with mem_done.
- sram_en  out  1  SRAM enable.
- sram_we  out  4  byte write enables; bit i = lane i (bits 8i+7:8i).
- sram_addr  out  ADDR_W  word address = mem_addr[ADDR_W+1:2].
- sram_wdata  out  32  lane-placed store data.
- sram_rdata  in  32  SRAM read data; valid on the last ACCESS cycle.

Behaviour:
- Clock and reset: one clock, clk. Reset rst is asynchronous and active-high.
- Reset: state=IDLE, counter=0. All outputs are 0, including mem_rdata, mem_done, mem_busy, mem_err and all sram_* outputs.
- FSM states: IDLE, ACCESS, DONE. All outputs are registered.
- IDLE:
  - If mem_req=1 on an edge, latch we, addr, wdata and dmtype.
  - If the access is misaligned, go to DONE with err=1. The SRAM is not touched.
  - Otherwise go to ACCESS and load counter=RD_LAT.
- ACCESS:
  - sram_en=1 throughout.
  - sram_we is non-zero only on the first ACCESS cycle, and only for stores.
  - Counter decrements each cycle. At counter=1, capture sram_rdata into mem_rdata (loads) and go to DONE.
- DONE: mem_done=1 for exactly one cycle, then IDLE. sram_en=0.
- mem_busy=1 in ACCESS and DONE. It is 0 in IDLE.
- Latency: request accepted at edge N → mem_done high in cycle N+RD_LAT+1. A misaligned request is done at N+1.
- Back-to-back: the next request is accepted at the first edge in IDLE. A request held high during busy is accepted once busy drops; mem_req is level-sampled.
- Alignment:
  - Half (001/010) is misaligned if addr[0]=1.
  - Word is misaligned if addr[1:0]!=00.
  - Byte is never misaligned.
- Store lane placement:
  - Byte: wdata[7:0] is replicated to all lanes; we = 1<<addr[1:0].
  - Half: wdata[15:0] is replicated to both halves; we = addr[1] ? 1100 : 0011.
  - Word: we=1111, data passed through unchanged.
- Load extraction:
  - Byte: lane addr[1:0] is selected. 011 sign-extends, 100 zero-extends.
  - Half: half addr[1] is selected. 001 sign-extends, 010 zero-extends.
  - Word: data passed through.
- Stores and errored accesses: mem_rdata=0 in DONE.
- Undefined dmtype 101..111 is treated as word.
- Reset mid-ACCESS: the transfer is aborted immediately. sram_en and sram_we drop asynchronously, no mem_done is produced, and the FSM restarts in IDLE.
- Address bits above ADDR_W+1 are ignored (the address wraps modulo SRAM size).

Optional Feature:
- Macro: DMEM_BRIDGE_MISALIGN_TRAP_EN.
- When defined: misaligned accesses behave as specified above — err=1, no SRAM access, done at N+1.
- When undefined:
  - mem_err is tied to 0.
  - Misaligned accesses are force-aligned: half clears addr[0], word clears addr[1:0].
  - The forced access proceeds through ACCESS with normal latency and lane rules.

Test Plan:
- Reset during ACCESS (RD_LAT=3, rst asserted on 2nd ACCESS cycle) → sram_en and sram_we go to 0 immediately, mem_busy=0, no mem_done pulse. A subsequent request completes normally.
- RD_LAT=1, word store addr=0x8, wdata=0xDEADBEEF → sram_addr=2, sram_we=1111, sram_wdata=0xDEADBEEF. mem_done at N+2, mem_rdata=0.
- Byte store addr=0x13, wdata=0x000000A5, then a 011 load from 0x13 and a 100 load from 0x13:
  - Store → sram_we=1000, sram_wdata=0xA5A5A5A5.
  - 011 load → 0xFFFFFFA5.
  - 100 load → 0x000000A5.
- Half store 0x8001 at addr=0x6, then a 001 load and a 010 load:
  - Store → sram_we=1100.
  - 001 load → 0xFFFF8001.
  - 010 load → 0x00008001.
- Word load addr=0x2 with trap enabled → mem_err=1, mem_done at N+1, sram_en never asserted. With trap disabled → SRAM read at word 0, mem_err=0.
- RD_LAT=4, two back-to-back loads with mem_req held high → second accepted the edge after the first done. Done pulses are 6 cycles apart, and each load returns its own word.
